imager_rx: RTL and testbench
============================

// Module: imager_rx
// PURPOSE
//  Capture-side receiver for the imager byte stream (hd/vd/pxq/dout).
//  Parses the 16-byte geometry header and assembles R,G,B bytes into 24-bit pixels tagged with x/y.
//  Buffers pixels in a small FIFO toward a valid/ready consumer (JPEG front end); the imager has no backpressure.
// PARAMETERS
//  FIFO_DEPTH  8   pixel FIFO entries, power of 2, >=2
//  DIM_W       16  width/height/coordinate bits; header values must fit
// PORTS
//  clk_in       in   1      clock, rising edge
//  rst_n        in   1      asynchronous reset, active low
//  enable       in   1      arm receiver; sampled only in IDLE
//  clr_err      in   1      clears err_sync/err_ovf
//  hd,vd,pxq    in   1      imager line sync, frame sync, byte qualifier
//  din          in   8      imager byte
//  pix_valid    out  1      FIFO head valid
//  pix_ready    in   1      consumer accepts head when valid&ready
//  pix_rgb      out  24     {R,G,B}; R is the first byte received
//  pix_x,pix_y  out  DIM_W  pixel coordinates, 0-based
//  pix_sof      out  1      pixel (0,0)
//  pix_eol      out  1      x==width-1
//  pix_eof      out  1      last pixel of frame
//  frame_width  out  DIM_W  x_high-x_low of current/last header
//  frame_height out  DIM_W  y_high-y_low of current/last header
//  busy         out  1      state != IDLE
//  frame_done   out  1      one-cycle pulse after last byte of good frame
//  err_sync     out  1      sticky protocol error
//  err_ovf      out  1      sticky FIFO overflow
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE; async assert, sync deassert.
//  Inputs hd/vd/din sampled only on cycles with pxq=1; pxq=0 cycles hold all state (gaps allowed).
//  States: IDLE -> HDR -> DATA -> IDLE.
//  IDLE: enable&pxq&!vd -> HDR, byte consumed as header byte 0. pxq&vd in IDLE -> err_sync, stay IDLE.
//  HDR: 16 bytes, four 32-bit fields LSB-first: x_low,x_high,y_low,y_high.
//   hd or vd during HDR -> err_sync, IDLE. Byte 15 sampled: width=x_high-x_low, height=y_high-y_low (32-bit).
//   width or height ==0, negative, or >=2^DIM_W -> err_sync, IDLE; else -> DATA.
//   frame_width/height update on next edge, held until next good header.
//  DATA: counters byte(0..2), x, y.
//   Required: hd=1 exactly when byte==0&&x==0; vd=1 exactly on first data byte. Any violation -> err_sync, frame aborted, IDLE.
//   Partial pixel is discarded; pixels already in FIFO remain.
//   byte 0->R, 1->G, 2->B. On B: pixel pushed at that edge; x++; x==width-1 wraps x=0,y++.
//   Last B (x==width-1,y==height-1): push with eof, frame_done pulse next cycle, -> IDLE.
//  FIFO: show-ahead; pix_valid rises the cycle after the B byte is sampled (latency 1).
//   Pop on pix_valid&pix_ready. Push and pop same cycle when full is allowed (no overflow).
//   Push when full and no pop: pixel dropped, err_ovf=1, frame parsing continues, frame_done still pulses.
//  Errors: sticky until clr_err. clr_err and new error on same edge -> error wins (flag stays 1).
//  enable deassert mid-frame is ignored; the frame completes. FIFO is never flushed except by reset.
//  Arithmetic: header subtraction 32-bit; counters DIM_W bits; no wrap possible after width/height checks.
// TESTING
//  T1 2x2: hdr x_low=0,x_high=2,y_low=0,y_high=2, bytes 01..0C, pix_ready=1
//     -> pixels 010203@(0,0) sof, 040506@(1,0) eol, 070809@(0,1), 0A0B0C@(1,1) eol+eof
//     -> frame_done 1 pulse; width=2, height=2.
//  T2 Offset: x_low=5,x_high=8,y_low=3,y_high=4 -> width=3, height=1; 3 pixels, x=0..2, y=0.
//     Insert random pxq=0 gaps -> same pixels.
//  T3 Overflow: FIFO_DEPTH=4, pix_ready=0, 3x2 frame -> 4 pixels held, err_ovf=1, frame_done pulses.
//     Then pix_ready=1 -> pixels (0,0)..(0,1) in order; clr_err -> err_ovf=0.
//  T4 Sync: 2x2 frame with hd=0 on first byte of line 1 -> err_sync=1, busy=0, only 2 pixels out.
//     Next good frame is received correctly.
//  T5 Bad header: x_high=x_low=7 -> err_sync=1, IDLE after byte 15, no pixels.
//     vd during header -> err_sync=1.
//  T6 Reset mid-DATA: rst_n low at pixel 1 -> all outputs 0, FIFO empty; a fresh frame after release is correct.

Source files
------------

// File: rtl/imager_rx.sv
// Capture-side receiver for the imager byte stream: parses the 16-byte geometry header,
// assembles R,G,B bytes into x/y-tagged pixels and buffers them in a show-ahead FIFO.
module imager_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIM_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_err,
  input  logic             hd,
  input  logic             vd,
  input  logic             pxq,
  input  logic [7:0]       din,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [23:0]      pix_rgb,
  output logic [DIM_W-1:0] pix_x,
  output logic [DIM_W-1:0] pix_y,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic [DIM_W-1:0] frame_width,
  output logic [DIM_W-1:0] frame_height,
  output logic             busy,
  output logic             frame_done,
  output logic             err_sync,
  output logic             err_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  typedef struct packed {
    logic [23:0]      rgb;
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_i_n;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  state_t           state, state_nx;
  logic [3:0]       hdr_cnt;
  logic [119:0]     hdr_sr;
  logic [127:0]     hdr_full;
  logic [31:0]      hdr_w, hdr_h;
  logic             hdr_ok;
  logic [1:0]       byte_cnt;
  logic [DIM_W-1:0] x_cnt, y_cnt;
  logic [7:0]       r_byte, g_byte;
  logic             first_in_line, first_in_frame, last_x, last_y;
  logic             sync_err, hdr_load, push, done;

  // Byte 15 is still on din when the geometry is evaluated.
  assign hdr_full = {din, hdr_sr};
  assign hdr_w    = hdr_full[63:32]  - hdr_full[31:0];
  assign hdr_h    = hdr_full[127:96] - hdr_full[95:64];
  assign hdr_ok   = (hdr_w != '0) && (hdr_w[31:DIM_W] == '0) &&
                    (hdr_h != '0) && (hdr_h[31:DIM_W] == '0);

  assign first_in_line  = (byte_cnt == 2'd0) && (x_cnt == '0);
  assign first_in_frame = first_in_line && (y_cnt == '0);
  assign last_x         = (x_cnt == frame_width  - DIM_W'(1));
  assign last_y         = (y_cnt == frame_height - DIM_W'(1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    sync_err = 1'b0;
    hdr_load = 1'b0;
    push     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (pxq) begin
        if (vd)          sync_err = 1'b1;
        else if (enable) state_nx = S_HDR;
      end
      S_HDR: if (pxq) begin
        if (hd || vd) begin
          sync_err = 1'b1;
          state_nx = S_IDLE;
        end else if (hdr_cnt == 4'd15) begin
          if (hdr_ok) begin
            hdr_load = 1'b1;
            state_nx = S_DATA;
          end else begin
            sync_err = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: if (pxq) begin
        if ((hd != first_in_line) || (vd != first_in_frame)) begin
          sync_err = 1'b1;
          state_nx = S_IDLE;
        end else if (byte_cnt == 2'd2) begin
          push = 1'b1;
          if (last_x && last_y) begin
            done     = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pixel FIFO bookkeeping
  pix_t          mem [FIFO_DEPTH];
  pix_t          push_pix, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, ovf;

  assign push_pix = '{rgb: {r_byte, g_byte, din}, x: x_cnt, y: y_cnt,
                      sof: (x_cnt == '0) && (y_cnt == '0), eol: last_x, eof: last_x && last_y};
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = pix_valid && pix_ready;
  assign wr_en = push && (!full || pop);
  assign ovf   = push && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state        <= S_IDLE;
      hdr_cnt      <= '0;
      hdr_sr       <= '0;
      byte_cnt     <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      r_byte       <= '0;
      g_byte       <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
      err_sync     <= 1'b0;
      err_ovf      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state      <= state_nx;
      frame_done <= done;
      err_sync   <= (err_sync & ~clr_err) | sync_err;
      err_ovf    <= (err_ovf  & ~clr_err) | ovf;

      if (pxq && state_nx == S_HDR) begin
        hdr_sr  <= {din, hdr_sr[119:8]};
        hdr_cnt <= hdr_cnt + 4'd1;
      end else if (state_nx != S_HDR) begin
        hdr_cnt <= '0;
      end

      if (hdr_load) begin
        frame_width  <= hdr_w[DIM_W-1:0];
        frame_height <= hdr_h[DIM_W-1:0];
        byte_cnt     <= '0;
        x_cnt        <= '0;
        y_cnt        <= '0;
      end else if (state == S_DATA && pxq && !sync_err) begin
        case (byte_cnt)
          2'd0: begin r_byte <= din; byte_cnt <= 2'd1; end
          2'd1: begin g_byte <= din; byte_cnt <= 2'd2; end
          default: begin
            byte_cnt <= 2'd0;
            if (last_x) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + DIM_W'(1);
            end else begin
              x_cnt <= x_cnt + DIM_W'(1);
            end
          end
        endcase
      end

      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: pixel storage has no reset; pointers and count define what is valid and outputs are gated.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= push_pix;
  end

  assign pix_valid = (count != '0);
  assign head      = pix_valid ? mem[rd_ptr] : '0;
  assign pix_rgb   = head.rgb;
  assign pix_x     = head.x;
  assign pix_y     = head.y;
  assign pix_sof   = head.sof;
  assign pix_eol   = head.eol;
  assign pix_eof   = head.eof;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_imager_rx.sv
// Directed bench for imager_rx: expected pixels are queued as bytes are driven and
// compared when the consumer side accepts them.
module tb_imager_rx;
  localparam int DIM_W      = 16;
  localparam int FIFO_DEPTH = 4;

  logic             clk_in, rst_n, enable, clr_err, hd, vd, pxq, pix_ready;
  logic [7:0]       din;
  logic             pix_valid, pix_sof, pix_eol, pix_eof;
  logic [23:0]      pix_rgb;
  logic [DIM_W-1:0] pix_x, pix_y, frame_width, frame_height;
  logic             busy, frame_done, err_sync, err_ovf;

  imager_rx #(.FIFO_DEPTH(FIFO_DEPTH), .DIM_W(DIM_W)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .hd(hd), .vd(vd), .pxq(pxq), .din(din),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_width(frame_width), .frame_height(frame_height), .busy(busy),
    .frame_done(frame_done), .err_sync(err_sync), .err_ovf(err_ovf)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef logic [58:0] pix_word_t;
  pix_word_t exp_q[$];
  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pix_word_t mk(input logic [23:0] rgb, input int x, input int y,
                                   input logic sof, input logic eol, input logic eof);
    return {rgb, 16'(x), 16'(y), sof, eol, eof};
  endfunction

  // Consumer-side scoreboard: a pixel is accepted on the next rising edge.
  always @(negedge clk_in) begin
    if (frame_done) done_cnt++;
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0)
        check("pix_unexpected", 64'(exp_q.size()), 64'd1);
      else
        check("pix", 64'({pix_rgb, pix_x, pix_y, pix_sof, pix_eol, pix_eof}), 64'(exp_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic h, input logic v);
    din = b; hd = h; vd = v; pxq = 1'b1;
    @(posedge clk_in);
    #1;
    pxq = 1'b0; hd = 1'b0; vd = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] xl, input logic [31:0] xh,
                             input logic [31:0] yl, input logic [31:0] yh);
    logic [127:0] f;
    f = {yh, yl, xh, xl};
    for (int i = 0; i < 16; i++) send_byte(f[i*8 +: 8], 1'b0, 1'b0);
  endtask

  // err_pix >= 0: byte 0 of that pixel carries the wrong hd and the frame stops there.
  // stop_byte >= 0: stop after that many data bytes. Only pixels below expect_n are expected out.
  task automatic send_frame(input int w, input int h, input logic [7:0] base, input bit gaps,
                            input int err_pix, input int expect_n, input int stop_byte,
                            input bit chk_lat);
    logic [7:0]  b;
    logic [23:0] rgb;
    logic        hv, vv;
    int          x, y, k;
    rgb = '0;
    for (int p = 0; p < w*h; p++) begin
      x = p % w;
      y = p / w;
      for (int j = 0; j < 3; j++) begin
        k = p*3 + j;
        if (stop_byte >= 0 && k >= stop_byte) return;
        if (gaps) idle(int'($urandom_range(0, 2)));
        b  = base + 8'(k);
        hv = (j == 0 && x == 0);
        vv = (j == 0 && p == 0);
        if (p == err_pix && j == 0) begin
          send_byte(b, !hv, vv);
          return;
        end
        send_byte(b, hv, vv);
        rgb = {rgb[15:0], b};
        if (chk_lat && p == 0 && j == 1) check("lat_before_b", 64'(pix_valid), 64'd0);
        if (j == 2) begin
          if (p < expect_n) exp_q.push_back(mk(rgb, x, y, p == 0, x == w-1, p == w*h-1));
          if (chk_lat && p == 0) check("lat_after_b", 64'(pix_valid), 64'd1);
        end
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !pix_valid) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [127:0] f;
    rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0; hd = 1'b0; vd = 1'b0;
    pxq = 1'b0; pix_ready = 1'b0; din = '0;
    idle(3);
    check("rst_pix", 64'({pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol, pix_eof}), 64'd0);
    check("rst_ctl", 64'({frame_width, frame_height, busy, frame_done, err_sync, err_ovf}), 64'd0);
    rst_n = 1'b1;
    idle(3);

    // T1: 2x2 frame, consumer always ready
    enable = 1'b1; pix_ready = 1'b1;
    send_header(0, 2, 0, 2);
    send_frame(2, 2, 8'h01, 1'b0, -1, 4, -1, 1'b1);
    idle(2);
    wait_drain("t1_drain");
    check("t1_done", 64'(done_cnt), 64'd1);
    check("t1_dims", 64'({frame_width, frame_height}), {32'd0, 16'd2, 16'd2});
    check("t1_flags", 64'({busy, err_sync, err_ovf}), 64'd0);

    // T2: offset header, once with random gaps and once without
    send_header(5, 8, 3, 4);
    check("t2_dims", 64'({frame_width, frame_height, busy}), {31'd0, 16'd3, 16'd1, 1'b1});
    send_frame(3, 1, 8'h20, 1'b1, -1, 3, -1, 1'b0);
    send_header(5, 8, 3, 4);
    send_frame(3, 1, 8'h20, 1'b0, -1, 3, -1, 1'b0);
    idle(2);
    wait_drain("t2_drain");
    check("t2_done", 64'(done_cnt), 64'd3);

    // T3: consumer stalled, 3x2 frame into a 4-entry FIFO
    pix_ready = 1'b0;
    send_header(0, 3, 0, 2);
    send_frame(3, 2, 8'h30, 1'b0, -1, 4, -1, 1'b1);
    idle(2);
    check("t3_state", 64'({pix_valid, busy, err_sync, err_ovf}), 64'b1001);
    check("t3_done", 64'(done_cnt), 64'd4);
    pix_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_ovf_sticky", 64'(err_ovf), 64'd1);
    pulse_clr();
    check("t3_ovf_clr", 64'(err_ovf), 64'd0);

    // T4: missing hd on the first byte of line 1, then a clean frame
    send_header(0, 2, 0, 2);
    send_frame(2, 2, 8'h40, 1'b0, 2, 4, -1, 1'b0);
    check("t4_err", 64'({err_sync, busy}), 64'b10);
    idle(2);
    wait_drain("t4_drain");
    check("t4_no_done", 64'(done_cnt), 64'd4);
    pulse_clr();
    check("t4_clr", 64'(err_sync), 64'd0);
    send_header(0, 2, 0, 2);
    send_frame(2, 2, 8'h50, 1'b0, -1, 4, -1, 1'b0);
    idle(2);
    wait_drain("t4_good_drain");
    check("t4_good_done", 64'({32'(done_cnt), 31'd0, err_sync}), {32'd5, 32'd0});

    // T5: zero-width header, vd inside a header, clr_err colliding with a new error
    f = {32'd2, 32'd0, 32'd7, 32'd7};
    for (int i = 0; i < 15; i++) send_byte(f[i*8 +: 8], 1'b0, 1'b0);
    check("t5_busy_hdr", 64'(busy), 64'd1);
    send_byte(f[127:120], 1'b0, 1'b0);
    check("t5_bad_hdr", 64'({err_sync, busy, pix_valid, frame_width}), {45'd0, 3'b100, 16'd2});
    idle(2);
    check("t5_no_pix", 64'(pix_valid), 64'd0);
    pulse_clr();
    for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    check("t5_vd_hdr", 64'({err_sync, busy}), 64'b10);
    clr_err = 1'b1;
    send_byte(8'h00, 1'b0, 1'b1);
    clr_err = 1'b0;
    check("t5_err_wins", 64'({err_sync, busy}), 64'b10);
    pulse_clr();
    check("t5_clr", 64'(err_sync), 64'd0);

    // T6: reset in the middle of pixel 1, then a fresh frame
    pix_ready = 1'b0;
    send_header(0, 2, 0, 2);
    send_frame(2, 2, 8'h60, 1'b0, -1, 0, 4, 1'b0);
    check("t6_pre", 64'({pix_valid, busy}), 64'b11);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pix", 64'({pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol, pix_eof}), 64'd0);
    check("t6_rst_ctl", 64'({frame_width, frame_height, busy, frame_done, err_sync, err_ovf}), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    pix_ready = 1'b1;
    send_header(0, 2, 0, 2);
    send_frame(2, 2, 8'h70, 1'b0, -1, 4, -1, 1'b1);
    idle(2);
    wait_drain("t6_drain");
    check("t6_final", 64'({32'(done_cnt), frame_width, 13'd0, busy, err_sync, err_ovf}),
          {32'd6, 16'd2, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
